// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared types for the RV32 hazard/scoreboard logic.
//   fwd_e     : ALU operand source select (register file, W stage, M stage)
//   fwdSelect : priority encoder for forwarding. M is younger than W, so M wins.
// ---------------------------------------------------------------------------
package riscv_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_e;

    // The caller has already excluded x0 from the hit terms.
    function automatic fwd_e fwdSelect(input logic hitM, input logic hitW);
        if (hitM) begin
            return FWD_M;
        end else if (hitW) begin
            return FWD_W;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_busy_table.sv
// ---------------------------------------------------------------------------
// busy_table
// One busy bit per architectural register. Each bit marks an outstanding
// long-latency write to that register.
//   clk, reset        : clock and synchronous active-high reset (clears all bits)
//   setEn, setAddr    : mark a register busy (long op issued)
//   clrEn, clrAddr    : mark a register free (long op written back)
//   rdAddrA/B/C       : three combinational read ports
//   busyA/B/C         : busy state of the addressed registers
// When the same register is set and cleared in one cycle, the set wins because
// the newly issued op is still in flight. x0 is hard-wired to not busy.
// ---------------------------------------------------------------------------
module busy_table
    import riscv_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              setEn,
    input  logic [REG_AW-1:0] setAddr,
    input  logic              clrEn,
    input  logic [REG_AW-1:0] clrAddr,
    input  logic [REG_AW-1:0] rdAddrA,
    input  logic [REG_AW-1:0] rdAddrB,
    input  logic [REG_AW-1:0] rdAddrC,
    output logic              busyA,
    output logic              busyB,
    output logic              busyC
);

    localparam int NREGS = 1 << REG_AW;

    logic [NREGS-1:0] busyReg;
    logic [NREGS-1:0] busyNext;

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_bit
            if (gi == 0) begin : g_zero
                assign busyNext[gi] = 1'b0;
            end else begin : g_reg
                localparam logic [REG_AW-1:0] IDX = REG_AW'(gi);
                assign busyNext[gi] = (setEn && (setAddr == IDX)) ? 1'b1 :
                                      (clrEn && (clrAddr == IDX)) ? 1'b0 :
                                      busyReg[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            busyReg <= '0;
        end else begin
            busyReg <= busyNext;
        end
    end

    assign busyA = busyReg[rdAddrA];
    assign busyB = busyReg[rdAddrB];
    assign busyC = busyReg[rdAddrC];

endmodule

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// Hazard unit for the 5-stage RV32 core, extended with a register scoreboard
// for long-latency ops (div/mul) that write back out of order.
//   clk, reset               : clock, synchronous active-high reset
//   Rs1D/Rs2D/RdD/RegWriteD  : decode-stage operands and destination
//   LongD                    : decode instruction is a long-latency op
//   Rs1E/Rs2E/RdE            : execute-stage operands and destination
//   ResultSrcE_zero          : execute instruction is a load
//   LongIssueE               : long op leaves E for the long unit this cycle
//   PCSrcE                   : taken branch/jump resolved in E
//   RdM/RegWriteM, RdW/RegWriteW : M/W destinations used for forwarding
//   LongWbValid/LongWbRd     : long unit writes the register file
//   StallF/StallD/FlushD/FlushE : pipeline control, same cycle as inputs
//   ForwardAE/ForwardBE      : ALU operand source select
//   StallCount/FlushCount    : saturating stall / flush cycle counters
//   ScbError                 : sticky, set by a writeback with nothing outstanding
// ---------------------------------------------------------------------------
module hazard_scoreboard
    import riscv_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int MAX_LONG = 4,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] RdD,
    input  logic              RegWriteD,
    input  logic              LongD,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic              ResultSrcE_zero,
    input  logic              LongIssueE,
    input  logic              PCSrcE,
    input  logic [REG_AW-1:0] RdM,
    input  logic              RegWriteM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteW,
    input  logic              LongWbValid,
    input  logic [REG_AW-1:0] LongWbRd,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output fwd_e              ForwardAE,
    output fwd_e              ForwardBE,
    output logic [CNT_W-1:0]  StallCount,
    output logic [CNT_W-1:0]  FlushCount,
    output logic              ScbError
);

    localparam int OUT_W = $clog2(MAX_LONG + 1);
    localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_LONG);

    logic [OUT_W-1:0] outstandingReg, outstandingNext;
    logic             scbErrorReg, scbErrorNext;
    logic [CNT_W-1:0] stallCountReg, flushCountReg;

    logic busyRs1, busyRs2, busyRd;
    logic ldStall, lgEStall, scbStall, fullStall, stall;

    // -----------------------------------------------------------------------
    // Scoreboard
    // -----------------------------------------------------------------------
    busy_table #(
        .REG_AW (REG_AW)
    ) u_busy (
        .clk     (clk),
        .reset   (reset),
        .setEn   (LongIssueE),
        .setAddr (RdE),
        .clrEn   (LongWbValid),
        .clrAddr (LongWbRd),
        .rdAddrA (Rs1D),
        .rdAddrB (Rs2D),
        .rdAddrC (RdD),
        .busyA   (busyRs1),
        .busyB   (busyRs2),
        .busyC   (busyRd)
    );

    // -----------------------------------------------------------------------
    // Forwarding
    // -----------------------------------------------------------------------
    assign ForwardAE = fwdSelect(RegWriteM && (RdM == Rs1E) && (Rs1E != '0),
                                 RegWriteW && (RdW == Rs1E) && (Rs1E != '0));
    assign ForwardBE = fwdSelect(RegWriteM && (RdM == Rs2E) && (Rs2E != '0),
                                 RegWriteW && (RdW == Rs2E) && (Rs2E != '0));

    // -----------------------------------------------------------------------
    // Stall / flush
    // -----------------------------------------------------------------------
    assign ldStall   = ResultSrcE_zero && (RdE != '0) &&
                       ((RdE == Rs1D) || (RdE == Rs2D));
    // The op leaving E is not in the table yet, so its hazard on D is
    // covered here directly (RAW on sources, WAW on the destination).
    assign lgEStall  = LongIssueE && (RdE != '0) &&
                       ((RdE == Rs1D) || (RdE == Rs2D) || (RegWriteD && (RdE == RdD)));
    assign scbStall  = busyRs1 || busyRs2 || (RegWriteD && busyRd);
    assign fullStall = LongD && (outstandingReg == MAX_OUT);
    assign stall     = ldStall || lgEStall || scbStall || fullStall;

    assign StallF = stall;
    assign StallD = stall;
    assign FlushD = PCSrcE;
    assign FlushE = stall || PCSrcE;

    // -----------------------------------------------------------------------
    // Outstanding long-op count and error flag
    // -----------------------------------------------------------------------
    always_comb begin
        outstandingNext = outstandingReg;
        scbErrorNext    = scbErrorReg;
        if (LongIssueE && !LongWbValid) begin
            if (outstandingReg != MAX_OUT) begin
                outstandingNext = outstandingReg + OUT_W'(1);
            end
        end else if (!LongIssueE && LongWbValid) begin
            if (outstandingReg == '0) begin
                // Writeback with nothing in flight: hold at zero, flag it.
                scbErrorNext = 1'b1;
            end else begin
                outstandingNext = outstandingReg - OUT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outstandingReg <= '0;
            scbErrorReg    <= 1'b0;
            stallCountReg  <= '0;
            flushCountReg  <= '0;
        end else begin
            outstandingReg <= outstandingNext;
            scbErrorReg    <= scbErrorNext;
            if (stall && (stallCountReg != '1)) begin
                stallCountReg <= stallCountReg + CNT_W'(1);
            end
            if (PCSrcE && (flushCountReg != '1)) begin
                flushCountReg <= flushCountReg + CNT_W'(1);
            end
        end
    end

    assign StallCount = stallCountReg;
    assign FlushCount = flushCountReg;
    assign ScbError   = scbErrorReg;

endmodule
